// File: rtl/fp_mult_pipe_if.sv
// fp_mult_pipe_if: operand/result valid-ready bus for fp_mult_pipe
interface fp_mult_pipe_if #(parameter int EXP_W = 8, parameter int MAN_W = 23);
  localparam int W = 1 + EXP_W + MAN_W;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic [4:0]   flags;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, res, flags);
  modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, res, flags);
endinterface

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage RNE floating-point multiplier with valid/ready flow control
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic         clk,
  input  logic         reset,
  fp_mult_pipe_if.slave bus
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int P = 2 * MAN_W + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic signed [EXP_W+1:0] BIAS = (EXP_W+2)'(2 ** (EXP_W - 1) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
  logic en;
  logic v1_q, v2_q, v3_q;
  logic [W-1:0] res_q, res_d;
  logic [4:0] flags_q, flags_d;
  logic s1_sign_q, s1_sign_d, s1_spc_q, s1_spc_d;
  logic signed [EXP_W+1:0] s1_exp_q, s1_exp_d;
  logic [MAN_W:0] s1_ma_q, s1_ma_d, s1_mb_q, s1_mb_d;
  logic [W-1:0] s1_spc_res_q, s1_spc_res_d;
  logic [4:0] s1_spc_flg_q, s1_spc_flg_d;
  logic s2_sign_q, s2_spc_q;
  logic signed [EXP_W+1:0] s2_exp_q;
  logic [P-1:0] s2_prod_q, s2_prod_d;
  logic [W-1:0] s2_spc_res_q;
  logic [4:0] s2_spc_flg_q;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, nan_res;
  logic hi, g, st, rnd, uf, of;
  logic [P-2:0] norm;
  logic [MAN_W-1:0] mant;
  logic [MAN_W:0] mant_r;
  logic signed [EXP_W+1:0] exp_n;
  assign en = !(v3_q && !bus.out_ready);
  assign bus.in_ready = en;
  assign bus.out_valid = v3_q;
  assign bus.res = res_q;
  assign bus.flags = flags_q;
  assign {ea, fa} = bus.a[W-2:0];
  assign {eb, fb} = bus.b[W-2:0];
  // subnormal operands classify as zero, so they flush without flags
  assign a_zero = ea == '0;
  assign b_zero = eb == '0;
  assign a_inf = ea == EMAX && fa == '0;
  assign b_inf = eb == EMAX && fb == '0;
  assign a_nan = ea == EMAX && fa != '0;
  assign b_nan = eb == EMAX && fb != '0;
  assign a_snan = a_nan && !fa[MAN_W-1];
  assign b_snan = b_nan && !fb[MAN_W-1];
  assign nan_res = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
  always_comb begin
    s1_sign_d = bus.a[W-1] ^ bus.b[W-1];
    s1_exp_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    s1_ma_d = {1'b1, fa};
    s1_mb_d = {1'b1, fb};
    s1_spc_d = nan_res || a_inf || b_inf || a_zero || b_zero;
    s1_spc_res_d = nan_res ? QNAN : (a_inf || b_inf) ? {s1_sign_d, EMAX, {MAN_W{1'b0}}} : {s1_sign_d, {(W-1){1'b0}}};
    s1_spc_flg_d = {a_snan || b_snan || (a_inf && b_zero) || (b_inf && a_zero), 4'b0000};
    s2_prod_d = P'(s1_ma_q) * P'(s1_mb_q);
  end
  // product lies in [1,4): shift left once unless the top bit is set
  always_comb begin
    hi = s2_prod_q[P-1];
    norm = hi ? s2_prod_q[P-2:0] : {s2_prod_q[P-3:0], 1'b0};
    mant = norm[P-2:MAN_W+1];
    g = norm[MAN_W];
    st = |norm[MAN_W-1:0];
    rnd = g && (st || mant[0]);
    mant_r = {1'b0, mant} + (MAN_W+1)'(rnd);
    exp_n = s2_exp_q + $signed({{(EXP_W+1){1'b0}}, hi}) + $signed({{(EXP_W+1){1'b0}}, mant_r[MAN_W]});
    uf = exp_n <= 0;
    of = exp_n >= $signed({2'b00, EMAX});
    res_d = s2_spc_q ? s2_spc_res_q : uf ? {s2_sign_q, {(W-1){1'b0}}} : of ? {s2_sign_q, EMAX, {MAN_W{1'b0}}} : {s2_sign_q, exp_n[EXP_W-1:0], mant_r[MAN_W-1:0]};
    flags_d = s2_spc_q ? s2_spc_flg_q : uf ? 5'b00011 : of ? 5'b00101 : {4'b0000, g || st};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      res_q <= '0;
      flags_q <= '0;
    end else if (en) begin
      v1_q <= bus.in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      res_q <= res_d;
      flags_q <= flags_d;
    end
  always_ff @(posedge clk)
    if (en) begin
      s1_sign_q <= s1_sign_d;
      s1_exp_q <= s1_exp_d;
      s1_ma_q <= s1_ma_d;
      s1_mb_q <= s1_mb_d;
      s1_spc_q <= s1_spc_d;
      s1_spc_res_q <= s1_spc_res_d;
      s1_spc_flg_q <= s1_spc_flg_d;
      s2_sign_q <= s1_sign_q;
      s2_exp_q <= s1_exp_q;
      s2_prod_q <= s2_prod_d;
      s2_spc_q <= s1_spc_q;
      s2_spc_res_q <= s1_spc_res_q;
      s2_spc_flg_q <= s1_spc_flg_q;
    end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed vectors, streaming/backpressure and reset checks
module tb_fp_mult_pipe;
  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;
  fp_mult_pipe_if #(.EXP_W(8), .MAN_W(23)) f();
  fp_mult_pipe_if #(.EXP_W(5), .MAN_W(10)) h();
  fp_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut_sp (.clk(clk), .reset(reset), .bus(f.slave));
  fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut_hp (.clk(clk), .reset(reset), .bus(h.slave));
  int checks = 0;
  int errors = 0;
  logic [31:0] va [11];
  logic [31:0] vb [11];
  logic [31:0] vr [11];
  logic [4:0]  vf [11];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask
  task automatic op(input string tag, input bit half, input logic [31:0] x, input logic [31:0] y,
                    input logic [31:0] er, input logic [4:0] ef);
    int n;
    @(negedge clk);
    if (half) begin h.in_valid = 1; h.a = x[15:0]; h.b = y[15:0]; end
    else begin f.in_valid = 1; f.a = x; f.b = y; end
    @(posedge clk);
    @(negedge clk);
    f.in_valid = 0;
    h.in_valid = 0;
    n = 1;
    while (!(half ? h.out_valid : f.out_valid) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, 3);
    check({tag, "_res"}, half ? {16'h0, h.res} : f.res, er);
    check({tag, "_flg"}, half ? {27'h0, h.flags} : {27'h0, f.flags}, {27'h0, ef});
  endtask
  initial begin
    int i, k, extra;
    logic [31:0] held;
    va = '{32'h40000000, 32'hBFC00000, 32'h3F800001, 32'h7F7FFFFF, 32'h00800000, 32'h7F800000,
           32'h7F800001, 32'hFF800000, 32'h00000001, 32'h80000000, 32'h7FC00000};
    vb = '{32'h40400000, 32'h40000000, 32'h3F800001, 32'h40000000, 32'h3F000000, 32'h00000000,
           32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F800000};
    vr = '{32'h40C00000, 32'hC0400000, 32'h3F800002, 32'h7F800000, 32'h00000000, 32'h7FC00000,
           32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h80000000, 32'h7FC00000};
    vf = '{5'h00, 5'h00, 5'h01, 5'h05, 5'h03, 5'h10, 5'h10, 5'h00, 5'h00, 5'h00, 5'h00};
    f.in_valid = 0; f.a = '0; f.b = '0; f.out_ready = 1;
    h.in_valid = 0; h.a = '0; h.b = '0; h.out_ready = 1;
    #1;
    check("rst_ov", f.out_valid, 0);
    check("rst_res", f.res, 0);
    check("rst_flg", f.flags, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("rst_rdy", f.in_ready, 1);
    for (int v = 0; v < 11; v++) op($sformatf("dir%0d", v), 0, va[v], vb[v], vr[v], vf[v]);
    op("half", 1, 32'h4000, 32'h4200, 32'h4600, 5'h00);
    i = 0;
    k = 0;
    held = '0;
    for (int c = 0; c < 60 && k < 8; c++) begin
      @(negedge clk);
      f.out_ready = !(c >= 5 && c <= 8);
      f.in_valid = i < 8;
      if (i < 8) begin f.a = va[i]; f.b = vb[i]; end
      #1;
      if (c == 5) begin
        check("stall_ov", f.out_valid, 1);
        check("stall_rdy", f.in_ready, 0);
        held = f.res;
      end
      if (c > 5 && c <= 8) check($sformatf("stall_hold%0d", c), f.res, held);
      if (f.out_valid && f.out_ready) begin
        check($sformatf("str%0d_res", k), f.res, vr[k]);
        check($sformatf("str%0d_flg", k), f.flags, vf[k]);
        k++;
      end
      if (f.in_valid && f.in_ready) i++;
    end
    check("stream_cnt", k, 8);
    f.in_valid = 0;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (f.out_valid) extra++;
    end
    check("stream_dup", extra, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      f.in_valid = 1;
      f.a = va[c];
      f.b = vb[c];
    end
    @(negedge clk);
    f.in_valid = 0;
    check("mid_pre_ov", f.out_valid, 1);
    reset = 0;
    #1;
    check("mid_rst_ov", f.out_valid, 0);
    check("mid_rst_res", f.res, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (f.out_valid) extra++;
    end
    check("mid_stale", extra, 0);
    check("mid_rdy", f.in_ready, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_mult_pipe.md
# fp_mult_pipe

Parametrised, fully pipelined IEEE-754-style floating-point multiplier with valid/ready flow control and exception flags. It is the next generation of the single-precision `fp_mult` core: the format is set by exponent/mantissa width parameters, rounding is round-to-nearest-even, and it sustains one product per clock. It sits between an operand source and a result sink in the FP datapath and can stall under sink backpressure.

## Interface
- `EXP_W`, default 8: exponent field width (≥3).
- `MAN_W`, default 23: stored fraction width (≥2). Word width `W = 1+EXP_W+MAN_W`.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands `a`/`b` are valid.
- `in_ready` output 1: block accepts operands this cycle.
- `a` input W: operand A (sign | exponent | fraction).
- `b` input W: operand B.
- `out_valid` output 1: `res`/`flags` are valid.
- `out_ready` input 1: sink accepts the result this cycle.
- `res` output W: product.
- `flags` output 5: [4] invalid, [3] divide-by-zero (always 0), [2] overflow, [1] underflow, [0] inexact.

## Operation
- Transfer in: `in_valid && in_ready` at a rising edge. Transfer out: `out_valid && out_ready`.
- Three register stages, each with its own valid bit:
  - S1: unpack, classify (zero, normal, inf, qNaN, sNaN), compute sign and raw exponent `ea+eb-bias` in EXP_W+2 signed bits. Bias is `2^(EXP_W-1)-1`.
  - S2: (MAN_W+1)x(MAN_W+1) unsigned significand product, 2*MAN_W+2 bits.
  - S3: normalise by 0 or 1 bit, round, detect overflow/underflow, pack result and flags.
- Subnormal inputs (exp=0, frac≠0) are treated as signed zero. The flush does not raise any flag.
- Subnormal or zero-rounding results flush to signed zero with underflow=1 and inexact=1.
- Rounding is RNE with guard, round and sticky bits. A mantissa carry-out on rounding increments the exponent.
- Overflow (biased exponent ≥ all-ones after rounding): `res` = signed infinity, overflow=1, inexact=1.
- Special cases:
  - Any NaN operand: `res` = canonical qNaN (sign 0, exp all-ones, fraction MSB 1, rest 0). invalid=1 only if an operand is sNaN.
  - inf × 0: canonical qNaN, invalid=1.
  - inf × finite nonzero, or inf × inf: signed infinity, flags 0.
  - zero × finite: signed zero, flags 0.
- Sign of every non-NaN result is `a[W-1]^b[W-1]`.

## Timing
- Latency is exactly 3 cycles, accept edge to `out_valid` high, when unstalled. Throughput is 1 result per cycle.
- Stall condition: `stall = out_valid && !out_ready`.
  - `in_ready = !stall`.
  - On a stall, all stages hold their contents, bubbles included.
  - No bubble collapsing.
- While stalled, `res`/`flags` are held stable.
- Bubble entry: `in_valid=0` with `in_ready=1` shifts a bubble into S1.
- Reset (async assert, sync release):
  - All stage valid bits and `out_valid` clear to 0; `res` and `flags` clear to 0.
  - `in_ready` = 1 once reset is released.
  - Operations in flight at assertion are discarded, and no output is produced for them.
- Datapath registers other than `res`/`flags` need not be reset.
- `flags` are valid only while `out_valid`=1 and always belong to the same result as `res`.

## Test plan
- 2.0 × 3.0 (0x40000000, 0x40400000), defaults: `res`=0x40C00000, flags=0, 3 cycles after accept. Also -1.5 × 2.0 (0xBFC00000, 0x40000000): `res`=0xC0400000.
- RNE rounding, 0x3F800001 × 0x3F800001: `res`=0x3F800002, flags=0x01.
- Overflow, 0x7F7FFFFF × 0x40000000: `res`=0x7F800000, flags=0x05.
- Underflow, 0x00800000 × 0x3F000000: `res`=0x00000000, flags=0x03.
- Special cases:
  - 0x7F800000 × 0x00000000: `res`=0x7FC00000, flags=0x10.
  - 0x7F800001 (sNaN) × 0x3F800000: `res`=0x7FC00000, flags=0x10.
  - 0xFF800000 × 0x40000000: `res`=0xFF800000, flags=0.
- Streaming and backpressure:
  - Drive 8 back-to-back operand pairs.
  - Hold `out_ready`=0 for 4 cycles mid-stream: `in_ready` drops in the same cycle, `res` stays stable, all 8 results arrive in order with none lost or duplicated.
  - Assert `reset` mid-stream: `out_valid`=0 immediately, and no stale result appears after release.
- Half precision, EXP_W=5, MAN_W=10: 0x4000 × 0x4200 gives `res`=0x4600, flags=0.
